// File: rtl/coso_calib_if.sv
// Handshake bundle between the COSO calibration controller and its environment
// (RNG unit beat-count stream, trim/enable controls, downstream sample stream).
interface coso_calib_if;
  logic        cal_start;
  logic [7:0]  cnt_in;
  logic        cnt_en;
  logic [31:0] param_out;
  logic        rng_en;
  logic [7:0]  out_data;
  logic        out_en;
  logic        locked;
  logic        cal_fail;

  modport master (
    output cal_start, cnt_in, cnt_en,
    input  param_out, rng_en, out_data, out_en, locked, cal_fail
  );

  modport slave (
    input  cal_start, cnt_in, cnt_en,
    output param_out, rng_en, out_data, out_en, locked, cal_fail
  );
endinterface

// File: rtl/coso_calib_ctrl.sv
// COSO TRNG auto-calibration: sweeps CRO-B trim until the averaged beat count
// falls in [TARGET_LO, TARGET_HI], then forwards beat counts while locked.
module coso_calib_ctrl #(
  parameter logic [7:0] TARGET_LO = 8'd16,
  parameter logic [7:0] TARGET_HI = 8'd64,
  parameter int         LOG2_AVG  = 4,
  parameter int         SETTLE_N  = 4,
  parameter logic [7:0] TRIM_A    = 8'h80,
  parameter int         MISS_MAX  = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  coso_calib_if.slave  bus
);

  localparam int         AW          = 8 + LOG2_AVG;
  localparam logic [8:0] AVG_LAST    = 9'((1 << LOG2_AVG) - 1);
  localparam logic [8:0] SETTLE_LAST = 9'(SETTLE_N - 1);
  localparam logic [7:0] MISS_LAST   = 8'(MISS_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_EVAL, S_LOCK, S_FAIL
  } state_e;

  state_e          state_q;
  logic [7:0]      trim_b_q;
  logic [7:0]      step_cnt_q;
  logic [8:0]      smp_cnt_q;
  logic [AW-1:0]   acc_q;
  logic [7:0]      miss_q;
  logic [7:0]      win_avg_q;
  logic            win_done_q;
  logic            rng_en_q;
  logic            out_en_q;
  logic [7:0]      out_data_q;
  logic            locked_q;
  logic            cal_fail_q;

  // Accumulator is wide enough for 2**LOG2_AVG full-scale samples.
  logic [AW-1:0]   acc_sum_d;
  logic [7:0]      avg_now_d;
  logic [7:0]      avg_end_d;

  assign acc_sum_d = acc_q + AW'(bus.cnt_in);
  assign avg_now_d = acc_q[AW-1:LOG2_AVG];
  assign avg_end_d = acc_sum_d[AW-1:LOG2_AVG];

  function automatic logic in_window(input logic [7:0] avg);
    return (avg >= TARGET_LO) && (avg <= TARGET_HI);
  endfunction

  // NOTE: all state lives in this one block and uses non-blocking assignments,
  // so every branch reads the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      trim_b_q   <= '0;
      step_cnt_q <= '0;
      smp_cnt_q  <= '0;
      acc_q      <= '0;
      miss_q     <= '0;
      win_avg_q  <= '0;
      win_done_q <= 1'b0;
      rng_en_q   <= 1'b0;
      out_en_q   <= 1'b0;
      out_data_q <= '0;
      locked_q   <= 1'b0;
      cal_fail_q <= 1'b0;
    end else begin
      out_en_q <= 1'b0;
      if (bus.cal_start) begin
        trim_b_q   <= '0;
        step_cnt_q <= '0;
        smp_cnt_q  <= '0;
        acc_q      <= '0;
        miss_q     <= '0;
        win_done_q <= 1'b0;
        locked_q   <= 1'b0;
        cal_fail_q <= 1'b0;
        rng_en_q   <= 1'b1;
        state_q    <= S_SETTLE;
      end else begin
        unique case (state_q)
          S_IDLE: rng_en_q <= 1'b0;
          S_SETTLE: if (bus.cnt_en) begin
            if (smp_cnt_q == SETTLE_LAST) begin
              smp_cnt_q <= '0;
              state_q   <= S_MEASURE;
            end else begin
              smp_cnt_q <= smp_cnt_q + 9'd1;
            end
          end
          S_MEASURE: if (bus.cnt_en) begin
            acc_q <= acc_sum_d;
            if (smp_cnt_q == AVG_LAST) begin
              smp_cnt_q <= '0;
              state_q   <= S_EVAL;
            end else begin
              smp_cnt_q <= smp_cnt_q + 9'd1;
            end
          end
          S_EVAL: begin
            acc_q <= '0;
            if (in_window(avg_now_d)) begin
              locked_q <= 1'b1;
              miss_q   <= '0;
              state_q  <= S_LOCK;
            end else if (step_cnt_q == 8'hFF) begin
              cal_fail_q <= 1'b1;
              rng_en_q   <= 1'b0;
              state_q    <= S_FAIL;
            end else begin
              trim_b_q   <= trim_b_q + 8'd1;
              step_cnt_q <= step_cnt_q + 8'd1;
              state_q    <= S_SETTLE;
            end
          end
          S_LOCK: begin
            // A completed window is judged one cycle after its last sample.
            if (win_done_q && !in_window(win_avg_q) && miss_q == MISS_LAST) begin
              locked_q   <= 1'b0;
              trim_b_q   <= trim_b_q + 8'd1;
              step_cnt_q <= '0;
              miss_q     <= '0;
              win_done_q <= 1'b0;
              acc_q      <= '0;
              smp_cnt_q  <= '0;
              state_q    <= S_SETTLE;
            end else begin
              if (win_done_q) begin
                win_done_q <= 1'b0;
                miss_q     <= in_window(win_avg_q) ? 8'd0 : miss_q + 8'd1;
              end
              if (bus.cnt_en) begin
                out_en_q   <= 1'b1;
                out_data_q <= bus.cnt_in;
                if (smp_cnt_q == AVG_LAST) begin
                  win_avg_q  <= avg_end_d;
                  win_done_q <= 1'b1;
                  acc_q      <= '0;
                  smp_cnt_q  <= '0;
                end else begin
                  acc_q     <= acc_sum_d;
                  smp_cnt_q <= smp_cnt_q + 9'd1;
                end
              end
            end
          end
          S_FAIL: rng_en_q <= 1'b0;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.param_out = {16'h0000, TRIM_A, trim_b_q};
  assign bus.rng_en    = rng_en_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_en    = out_en_q;
  assign bus.locked    = locked_q;
  assign bus.cal_fail  = cal_fail_q;

endmodule

// File: tb/tb_coso_calib_ctrl.sv
// Bench for coso_calib_ctrl: a sample-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_coso_calib_ctrl;

  localparam int TARGET_LO = 16;
  localparam int TARGET_HI = 64;
  localparam int WIN       = 16;
  localparam int SETTLE_N  = 4;
  localparam int MISS_MAX  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coso_calib_if bus ();
  coso_calib_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int bad_out_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sample-level view) ----------------
  typedef enum {P_OFF, P_SKIP, P_AVG, P_DECIDE, P_TRACK, P_DEAD} phase_e;
  phase_e     m_phase;
  int         m_trim, m_steps, m_skip, m_miss, m_held;
  bit         m_locked, m_fail, m_rng, m_out_en, m_pend, m_drop;
  logic [7:0] m_out_data;
  int         win[$];

  function automatic int win_avg();
    int s = 0;
    foreach (win[i]) s += win[i];
    return s / WIN;
  endfunction

  function automatic bit in_target(input int a);
    return (a >= TARGET_LO) && (a <= TARGET_HI);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = P_OFF; m_trim = 0; m_steps = 0; m_skip = 0; m_miss = 0; m_held = 0;
      m_locked = 0; m_fail = 0; m_rng = 0; m_out_en = 0; m_pend = 0; m_out_data = 8'h00;
      win.delete();
    end else begin
      m_out_en = 0;
      if (bus.cal_start) begin
        m_trim = 0; m_steps = 0; m_skip = 0; m_miss = 0; m_pend = 0;
        m_locked = 0; m_fail = 0; m_rng = 1; m_phase = P_SKIP;
        win.delete();
      end else begin
        case (m_phase)
          P_SKIP: if (bus.cnt_en) begin
            m_skip++;
            if (m_skip == SETTLE_N) begin m_skip = 0; m_phase = P_AVG; end
          end
          P_AVG: if (bus.cnt_en) begin
            win.push_back(int'(bus.cnt_in));
            if (win.size() == WIN) m_phase = P_DECIDE;
          end
          P_DECIDE: begin
            m_held = win_avg();
            win.delete();
            if (in_target(m_held)) begin
              m_locked = 1; m_miss = 0; m_phase = P_TRACK;
            end else if (m_steps == 255) begin
              m_fail = 1; m_rng = 0; m_phase = P_DEAD;
            end else begin
              m_trim = (m_trim + 1) % 256; m_steps++; m_phase = P_SKIP;
            end
          end
          P_TRACK: begin
            m_drop = 0;
            if (m_pend) begin
              m_pend = 0;
              if (in_target(m_held)) m_miss = 0;
              else begin
                m_miss++;
                if (m_miss == MISS_MAX) begin
                  m_drop = 1; m_locked = 0; m_trim = (m_trim + 1) % 256;
                  m_steps = 0; m_miss = 0; m_phase = P_SKIP; win.delete();
                end
              end
            end
            if (!m_drop && bus.cnt_en) begin
              m_out_en = 1; m_out_data = bus.cnt_in;
              win.push_back(int'(bus.cnt_in));
              if (win.size() == WIN) begin m_held = win_avg(); win.delete(); m_pend = 1; end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    #1;
    check("param_out", bus.param_out, {16'h0000, 8'h80, 8'(m_trim)});
    check("rng_en",    32'(bus.rng_en),   32'(m_rng));
    check("locked",    32'(bus.locked),   32'(m_locked));
    check("cal_fail",  32'(bus.cal_fail), 32'(m_fail));
    check("out_en",    32'(bus.out_en),   32'(m_out_en));
    check("out_data",  32'(bus.out_data), 32'(m_out_data));
    if (bus.out_en && !bus.locked) bad_out_en++;
  end

  // ---------------- RNG unit stand-in and drivers ----------------
  int plant_mode = 0;

  function automatic logic [7:0] plant();
    logic [7:0] t;
    t = bus.param_out[7:0];
    case (plant_mode)
      0: return (t < 8'd5) ? 8'd200 : 8'd40;
      1: return (t == 8'd0) ? 8'd15 : (t == 8'd1) ? 8'd65 : (t == 8'd2) ? 8'd16 : 8'd0;
      2: return (t == 8'd0) ? 8'd15 : (t == 8'd1) ? 8'd65 : (t == 8'd2) ? 8'd64 : 8'd0;
      default: return 8'd255;
    endcase
  endfunction

  task automatic tick(input bit ce, input logic [7:0] ci);
    bus.cnt_en = ce;
    bus.cnt_in = ci;
    @(negedge clk);
    bus.cnt_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.cal_start = 1'b1;
    @(negedge clk);
    bus.cal_start = 1'b0;
  endtask

  task automatic feed_n(input int n, input int gap, input logic [7:0] v);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, v);
      repeat (gap) tick(1'b0, 8'h00);
    end
  endtask

  // Feed plant samples until locked (which=0) or cal_fail (which=1), bounded.
  task automatic feed_until(input string name, input int which, input int gap, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick(1'b1, plant());
      repeat (gap) tick(1'b0, 8'h00);
      done = (which == 0) ? bus.locked : bus.cal_fail;
    end
    check(name, 32'(done), 32'd1);
  endtask

  initial begin
    bus.cal_start = 1'b0;
    bus.cnt_en    = 1'b0;
    bus.cnt_in    = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_param", bus.param_out, 32'h0000_8000);
    rst_n = 1'b1;

    // 1: reset in the middle of a measurement window
    pulse_start();
    feed_n(6, 1, 8'd200);
    check("pre_reset_rng_en", 32'(bus.rng_en), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_param",    bus.param_out,       32'h0000_8000);
    check("rst_rng_en",   32'(bus.rng_en),     32'd0);
    check("rst_locked",   32'(bus.locked),     32'd0);
    check("rst_cal_fail", 32'(bus.cal_fail),   32'd0);
    check("rst_out_en",   32'(bus.out_en),     32'd0);
    check("rst_out_data", 32'(bus.out_data),   32'd0);
    rst_n = 1'b1;
    feed_n(6, 1, 8'd40);
    check("idle_rng_en", 32'(bus.rng_en), 32'd0);
    check("idle_locked", 32'(bus.locked), 32'd0);

    // 2: sweep to trim 5
    plant_mode = 0;
    pulse_start();
    feed_until("lock_t2_timeout", 0, 1, 400);
    check("lock_t2_param", bus.param_out, 32'h0000_8005);

    // 3: boundaries, back-to-back strobes (EVAL-cycle strobe is dropped)
    plant_mode = 1;
    pulse_start();
    feed_until("lock_16_timeout", 0, 0, 400);
    check("lock_16_param", bus.param_out, 32'h0000_8002);
    plant_mode = 2;
    pulse_start();
    feed_until("lock_64_timeout", 0, 0, 400);
    check("lock_64_param", bus.param_out, 32'h0000_8002);

    // 5: loss of lock after two bad windows, then tolerance of a single bad one
    plant_mode = 0;
    pulse_start();
    feed_until("lock_t5_timeout", 0, 1, 400);
    feed_n(2 * WIN, 1, 8'd3);
    check("relock_drop_locked", 32'(bus.locked), 32'd0);
    check("relock_drop_param",  bus.param_out,   32'h0000_8006);
    feed_until("relock_timeout", 0, 1, 400);
    check("relock_param", bus.param_out, 32'h0000_8006);
    feed_n(WIN, 1, 8'd3);
    feed_n(WIN, 1, 8'd40);
    check("one_miss_locked", 32'(bus.locked), 32'd1);

    // 6: forwarding latency
    bus.cnt_en = 1'b1;
    bus.cnt_in = 8'h2A;
    @(negedge clk);
    bus.cnt_en = 1'b0;
    check("fwd_out_en",   32'(bus.out_en),   32'd1);
    check("fwd_out_data", 32'(bus.out_data), 32'h2A);
    @(negedge clk);
    check("fwd_out_en_clear", 32'(bus.out_en), 32'd0);

    // 4: no trim ever works
    plant_mode = 3;
    pulse_start();
    feed_until("fail_timeout", 1, 0, 6000);
    check("fail_rng_en", 32'(bus.rng_en), 32'd0);
    check("fail_locked", 32'(bus.locked), 32'd0);
    check("fail_param",  bus.param_out,   32'h0000_80FF);
    feed_n(20, 0, 8'd40);
    check("fail_hold", 32'(bus.cal_fail), 32'd1);

    check("out_en_outside_lock", 32'(bad_out_en), 32'd0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d mismatched so far", n_err);
    $fatal(1, "watchdog");
  end

endmodule
